// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_INST_W = 32;
  localparam int unsigned INST_BYTES   = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/rd_bus_interface.sv
// Read-only bus between a master issuing addresses and a zero-wait-state slave.
interface RdBusInterface #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0] RdData;

  modport Master (output Addr, input RdData);
  modport Slave  (input Addr, output RdData);

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {pc, inst} entries; the head is always a register.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  fetch_entry_t tail;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);

  // Shift-style storage: entries move from tail into head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (empty) head <= wdata;
          else       tail <= wdata;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (full) begin
            head <= tail;
            tail <= wdata;
          end else begin
            head <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter, fetch/issue arbitration and jump redirect for the program bus master.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  RdBusInterface.Master         io_PgmBus,
  input  logic                  i_Jump,
  input  logic [ADDR_WIDTH-1:0] i_JumpAddr,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic [INST_WIDTH-1:0] o_Inst,
  output logic [ADDR_WIDTH-1:0] o_PC
);

  logic [ADDR_WIDTH-1:0] pc;
  logic                  pop_c;
  logic                  push_c;
  logic                  empty;
  logic                  full;
  fetch_entry_t          wdata;
  fetch_entry_t          head;

  assign io_PgmBus.Addr = pc;

  // A redirect masks the head so decode never consumes a stale instruction.
  assign o_Valid = !empty & !i_Jump;
  assign pop_c   = o_Valid & i_Ready;
  assign push_c  = !i_Jump & (!full | pop_c);

  assign wdata.pc   = FETCH_ADDR_W'(pc);
  assign wdata.inst = FETCH_INST_W'(io_PgmBus.RdData);

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      pc <= RESET_ADDR;
    end else if (i_Jump) begin
      pc <= {i_JumpAddr[ADDR_WIDTH-1:2], 2'b00};
    end else if (push_c) begin
      pc <= pc + ADDR_WIDTH'(INST_BYTES);
    end
  end

  fetch_fifo u_fifo (
    .clk   (i_Clock),
    .rst_n (i_Reset),
    .push  (push_c),
    .pop   (pop_c),
    .flush (i_Jump),
    .wdata (wdata),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  assign o_Inst = INST_WIDTH'(head.inst);
  assign o_PC   = ADDR_WIDTH'(head.pc);

endmodule
